// File: rtl/load_store_unit.sv
// Load/store unit: converts one datapath load/store into one 64-bit handshaked bus transaction,
// with lane steering, load extension, PC stall, and fault on misaligned/illegal access or timeout.
module load_store_unit #(
   parameter int WIDTH   = 64,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             memRead,
   input  logic             memWrite,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] dataAddress,
   input  logic [WIDTH-1:0] writeData,
   output logic [WIDTH-1:0] readData,
   output logic             stall,
   output logic             fault,
   output logic             busReq,
   output logic             busWe,
   output logic [WIDTH-1:0] busAddr,
   output logic [WIDTH-1:0] busWdata,
   output logic [7:0]       busWstrb,
   input  logic             busAck,
   input  logic [WIDTH-1:0] busRdata,
   output logic [1:0]       lsu_state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   // Bus handshake: busReq rises in REQ and stays high with stable address/data/strobes until
   // busAck is seen on a rising edge; busAck outside REQ is ignored.
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] addr_q, wdata_q;
   logic [1:0]       size_q;
   logic             uns_q, we_q, to_q;
   logic [7:0]       strb_q;
   logic [CW-1:0]    cnt_q;

   logic             req, illegal, misal, bad;
   logic [2:0]       lane;
   logic [7:0]       strb_new;
   logic [WIDTH-1:0] wdata_new;
   logic [WIDTH-1:0] sh, ext;
   logic             accept, reject, ack_take, timeout_hit;

   assign req  = (memRead | memWrite) & ~rst;
   assign lane = dataAddress[2:0];

   always_comb begin
      illegal = (memRead & memWrite) | (memRead & (funct3 == 3'b111)) | (memWrite & funct3[2]);
      misal   = 1'b0;
      case (funct3[1:0])
         2'b01:   misal = dataAddress[0];
         2'b10:   misal = |dataAddress[1:0];
         2'b11:   misal = |dataAddress[2:0];
         default: misal = 1'b0;
      endcase
      bad = illegal | misal;
   end

   always_comb begin
      strb_new = 8'h00;
      case (funct3[1:0])
         2'b00:   strb_new = 8'h01 << lane;
         2'b01:   strb_new = 8'h03 << lane;
         2'b10:   strb_new = 8'h0F << lane;
         default: strb_new = 8'hFF;
      endcase
      wdata_new = writeData << {lane, 3'b000};
   end

   // Load data: bring the addressed lane down to bit 0, then extend by size.
   always_comb begin
      sh  = busRdata >> {addr_q[2:0], 3'b000};
      ext = sh;
      case (size_q)
         2'b00:   ext = uns_q ? {{(WIDTH-8){1'b0}}, sh[7:0]}   : {{(WIDTH-8){sh[7]}}, sh[7:0]};
         2'b01:   ext = uns_q ? {{(WIDTH-16){1'b0}}, sh[15:0]} : {{(WIDTH-16){sh[15]}}, sh[15:0]};
         2'b10:   ext = uns_q ? {{(WIDTH-32){1'b0}}, sh[31:0]} : {{(WIDTH-32){sh[31]}}, sh[31:0]};
         default: ext = sh;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      fault       = 1'b0;
      busReq      = 1'b0;
      accept      = 1'b0;
      reject      = 1'b0;
      ack_take    = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && bad) begin
               fault  = 1'b1;
               reject = 1'b1;
            end else if (req) begin
               stall   = 1'b1;
               accept  = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            stall  = 1'b1;
            busReq = 1'b1;
            if (busAck) begin
               ack_take = 1'b1;
               state_d  = DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            fault   = to_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= 2'b00;
         uns_q    <= 1'b0;
         we_q     <= 1'b0;
         strb_q   <= 8'h00;
         cnt_q    <= '0;
         to_q     <= 1'b0;
         readData <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= dataAddress;
            wdata_q <= wdata_new;
            size_q  <= funct3[1:0];
            uns_q   <= funct3[2];
            we_q    <= memWrite;
            strb_q  <= strb_new;
            cnt_q   <= '0;
            to_q    <= 1'b0;
         end
         if (reject) readData <= '0;
         if (state_q == REQ && cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + 1'b1;
         if (ack_take && !we_q) readData <= ext;
         if (timeout_hit) begin
            readData <= '0;
            to_q     <= 1'b1;
         end
         if (state_q == DONE) to_q <= 1'b0;
      end
   end

   assign busWe     = (state_q == REQ) & we_q;
   assign busWstrb  = busWe ? strb_q : 8'h00;
   assign busAddr   = {addr_q[WIDTH-1:3], 3'b000};
   assign busWdata  = wdata_q;
   assign lsu_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed + randomized bench for load_store_unit: scoreboard of expected load results,
// checked with immediate assertions.
module tb_load_store_unit;

   localparam int WIDTH   = 64;
   localparam int TIMEOUT = 255;

   logic             clk = 1'b0;
   logic             rst, memRead, memWrite, busAck;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] dataAddress, writeData, busRdata;
   logic [WIDTH-1:0] readData, busAddr, busWdata;
   logic             stall, fault, busReq, busWe;
   logic [7:0]       busWstrb;
   logic [1:0]       lsu_state;

   int errors = 0;
   int checks = 0;
   logic [WIDTH-1:0] exp_q[$];

   load_store_unit #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
      .dataAddress(dataAddress), .writeData(writeData), .readData(readData), .stall(stall),
      .fault(fault), .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busWdata(busWdata),
      .busWstrb(busWstrb), .busAck(busAck), .busRdata(busRdata), .lsu_state(lsu_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Byte-by-byte reference for load extraction and extension.
   function automatic logic [WIDTH-1:0] model_load(input logic [2:0] f3, input logic [WIDTH-1:0] addr,
                                                   input logic [WIDTH-1:0] rdata);
      logic [WIDTH-1:0] r;
      int a, n;
      r = '0;
      a = int'(addr[2:0]);
      n = 1 << f3[1:0];
      for (int i = 0; i < n; i++) r[8*i +: 8] = rdata[8*(a+i) +: 8];
      if (!f3[2] && r[8*n-1])
         for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
      return r;
   endfunction

   function automatic logic [7:0] model_strb(input logic [2:0] f3, input logic [WIDTH-1:0] addr);
      logic [7:0] s;
      int a, n;
      s = 8'h00;
      a = int'(addr[2:0]);
      n = 1 << f3[1:0];
      for (int i = 0; i < n; i++) s[a+i] = 1'b1;
      return s;
   endfunction

   // One legal access; ack_at = REQ cycle in which busAck is driven, 0 = never (timeout).
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wd,
                            input logic [WIDTH-1:0] rdata, input int ack_at, input string tag);
      int req_cycles;
      int stall_cycles;
      logic [WIDTH-1:0] exp_rd;
      req_cycles   = 0;
      stall_cycles = 0;
      if (rd) exp_q.push_back((ack_at == 0) ? '0 : model_load(f3, addr, rdata));
      memRead = rd; memWrite = wr; funct3 = f3; dataAddress = addr; writeData = wd; busRdata = rdata;
      #1;
      check({tag, "_stall_idle"}, stall, 1'b1);
      check({tag, "_fault_idle"}, fault, 1'b0);
      if (stall) stall_cycles = 1;
      for (int c = 0; c < TIMEOUT + 10; c++) begin
         @(negedge clk);
         busAck = 1'b0;
         if (!stall) break;
         stall_cycles++;
         if (busReq) begin
            req_cycles++;
            if (req_cycles == 1) begin
               check({tag, "_busAddr"}, busAddr, {addr[WIDTH-1:3], 3'b000});
               check({tag, "_busWe"}, busWe, wr);
               check({tag, "_busWstrb"}, busWstrb, wr ? model_strb(f3, addr) : 8'h00);
               if (wr) check({tag, "_busWdata"}, busWdata, wd << (8 * int'(addr[2:0])));
            end
            if (req_cycles == ack_at) busAck = 1'b1;
         end
      end
      memRead = 1'b0; memWrite = 1'b0;
      check({tag, "_stall_done"}, stall, 1'b0);
      check({tag, "_busReq_done"}, busReq, 1'b0);
      if (ack_at > 0) begin
         check({tag, "_stall_cycles"}, stall_cycles, ack_at + 1);
         check({tag, "_fault_done"}, fault, 1'b0);
      end else begin
         check({tag, "_req_cycles"}, req_cycles, TIMEOUT);
         check({tag, "_timeout_fault"}, fault, 1'b1);
      end
      if (rd) begin
         exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         check({tag, "_readData"}, readData, exp_rd);
         @(negedge clk);
         check({tag, "_readData_hold"}, readData, exp_rd);
         check({tag, "_fault_clear"}, fault, 1'b0);
      end else begin
         @(negedge clk);
      end
   endtask

   // Illegal or misaligned request: single fault cycle, no bus activity, readData cleared.
   task automatic do_bad(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [WIDTH-1:0] addr, input string tag);
      memRead = rd; memWrite = wr; funct3 = f3; dataAddress = addr;
      #1;
      check({tag, "_fault"}, fault, 1'b1);
      check({tag, "_stall"}, stall, 1'b0);
      check({tag, "_busReq"}, busReq, 1'b0);
      @(negedge clk);
      memRead = 1'b0; memWrite = 1'b0;
      #1;
      check({tag, "_fault_pulse"}, fault, 1'b0);
      check({tag, "_busReq_after"}, busReq, 1'b0);
      check({tag, "_readData_zero"}, readData, '0);
      @(negedge clk);
   endtask

   initial begin
      logic [2:0]       f3;
      logic [WIDTH-1:0] a;
      rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; busAck = 1'b0; funct3 = 3'b000;
      dataAddress = '0; writeData = '0; busRdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_busReq", busReq, 1'b0);
      check("rst_busWe", busWe, 1'b0);
      check("rst_busWstrb", busWstrb, 8'h00);
      check("rst_readData", readData, '0);
      check("rst_fault", fault, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_state", lsu_state, 2'd0);
      @(negedge clk);

      do_access(1, 0, 3'b011, 64'h100, '0, 64'h8877665544332211, 3, "ld_100");
      check("ld_100_value", readData, 64'h8877665544332211);
      do_access(1, 0, 3'b000, 64'h107, '0, 64'h8877665544332211, 1, "lb_107");
      check("lb_107_value", readData, 64'hFFFFFFFFFFFFFF88);
      do_access(1, 0, 3'b100, 64'h107, '0, 64'h8877665544332211, 2, "lbu_107");
      check("lbu_107_value", readData, 64'h0000000000000088);
      do_access(0, 1, 3'b001, 64'h10A, 64'hBEEF, '0, 2, "sh_10a");
      do_access(0, 1, 3'b011, 64'h118, 64'h0123456789ABCDEF, '0, 1, "sd_118");
      do_access(0, 1, 3'b000, 64'h125, 64'h5A, '0, 4, "sb_125");
      do_access(1, 0, 3'b001, 64'h136, '0, 64'h8001_0000_0000_0000, 2, "lh_136");
      do_access(1, 0, 3'b110, 64'h144, '0, 64'hF000_0000_0000_0000, 1, "lwu_144");

      do_bad(1, 0, 3'b010, 64'h102, "lw_misal");
      do_bad(1, 0, 3'b111, 64'h100, "load_111");
      do_bad(0, 1, 3'b100, 64'h100, "store_unsigned");
      do_bad(1, 1, 3'b011, 64'h100, "rd_and_wr");
      do_bad(0, 1, 3'b011, 64'h104, "sd_misal");

      busAck = 1'b1;
      @(negedge clk);
      check("stray_ack_busReq", busReq, 1'b0);
      check("stray_ack_state", lsu_state, 2'd0);
      busAck = 1'b0;

      do_access(1, 0, 3'b011, 64'h200, '0, 64'hDEADBEEFDEADBEEF, 0, "ld_timeout");

      memRead = 1'b1; funct3 = 3'b011; dataAddress = 64'h300; busRdata = 64'h1111;
      @(negedge clk);
      check("rstreq_busReq1", busReq, 1'b1);
      @(negedge clk);
      check("rstreq_busReq2", busReq, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("rstreq_busReq_low", busReq, 1'b0);
      check("rstreq_state", lsu_state, 2'd0);
      check("rstreq_readData", readData, '0);
      rst = 1'b0; memRead = 1'b0; busAck = 1'b1;
      @(negedge clk);
      check("late_ack_busReq", busReq, 1'b0);
      check("late_ack_stall", stall, 1'b0);
      busAck = 1'b0;
      do_access(1, 0, 3'b011, 64'h308, '0, 64'h0A0B0C0D0E0F1011, 2, "ld_after_rst");

      for (int i = 0; i < 6; i++) begin
         f3 = 3'($urandom_range(0, 6));
         a  = 64'h400 + 64'($urandom_range(0, 7));
         a[2:0] = a[2:0] & ~3'((1 << f3[1:0]) - 1);
         do_access(1, 0, f3, a, '0, {$urandom, $urandom}, $urandom_range(1, 4), "rand_load");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
